// File: rtl/dac_update_scheduler.sv
// Round-robin DAC write scheduler: applies one channel write at a time and holds off the next
// changed write until the stream has shipped SYNC_FRAMES frames carrying the new value.
module dac_update_scheduler #(
    parameter int NREQ        = 2,
    parameter int SYNC_FRAMES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic                CLK_24MHZ_FPGA,
    input  logic                SYSRST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [2*NREQ-1:0]   REQ_CH,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    output logic [NREQ-1:0]     ACK,
    output logic [NREQ-1:0]     NACK,
    input  logic                SYNC,
    input  logic                PLDRESETn,
    output logic [7:0]          DAC_DINA,
    output logic [7:0]          DAC_DINB,
    output logic [7:0]          DAC_DINC,
    output logic                BUSY,
    output logic                ERR
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [IW-1:0]       ptr_r, ptr_nxt_s;
    logic [IW-1:0]       win_idx_r, win_idx_nxt_s;
    logic [1:0]          win_ch_r, win_ch_nxt_s;
    logic [7:0]          win_data_r, win_data_nxt_s;
    logic [7:0]          dac_a_r, dac_b_r, dac_c_r;
    logic [7:0]          dac_a_nxt_s, dac_b_nxt_s, dac_c_nxt_s;
    logic [NREQ-1:0]     ack_r, ack_nxt_s, nack_r, nack_nxt_s;
    logic                busy_r, err_r, err_nxt_s;
    logic [3:0]          frame_cnt_r, frame_cnt_nxt_s;
    logic [15:0]         tmo_r, tmo_nxt_s;
    logic                sync_meta_r, sync_sync_r, sync_prev_r;
    logic                pld_meta_r, pld_ready_r;
    logic                sync_edge_s;
    logic                arb_found_s;
    logic [IW-1:0]       arb_idx_s;
    logic [1:0]          arb_ch_s;
    logic [7:0]          arb_data_s;
    logic [7:0]          cur_val_s;
    logic [NREQ-1:0]     win_onehot_s;

    assign sync_edge_s = sync_sync_r & ~sync_prev_r;

    // Two-flop synchronisers for the stream-domain SYNC and PLDRESETn, plus SYNC edge history
    always_ff @(posedge CLK_24MHZ_FPGA) begin
        if (SYSRST) begin
            sync_meta_r <= 1'b0;
            sync_sync_r <= 1'b0;
            sync_prev_r <= 1'b0;
            pld_meta_r  <= 1'b0;
            pld_ready_r <= 1'b0;
        end else begin
            sync_meta_r <= SYNC;
            sync_sync_r <= sync_meta_r;
            sync_prev_r <= sync_sync_r;
            pld_meta_r  <= PLDRESETn;
            pld_ready_r <= pld_meta_r;
        end
    end

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall
    always_comb begin
        arb_found_s = |REQ;
        arb_idx_s   = {IW{1'b0}};
        arb_ch_s    = 2'd0;
        arb_data_s  = 8'h00;
        for (int i = NREQ - 1; i >= 0; i--) begin
            arb_idx_s = REQ[i] ? IW'(i) : arb_idx_s;
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            arb_idx_s = (REQ[i] && (IW'(i) >= ptr_r)) ? IW'(i) : arb_idx_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            arb_ch_s   = (arb_idx_s == IW'(i)) ? REQ_CH[2*i +: 2]   : arb_ch_s;
            arb_data_s = (arb_idx_s == IW'(i)) ? REQ_DATA[8*i +: 8] : arb_data_s;
        end
    end

    // Current value of the latched channel, used to skip the frame wait on no-change writes
    always_comb begin
        case (win_ch_r)
            2'd0:    cur_val_s = dac_a_r;
            2'd1:    cur_val_s = dac_b_r;
            2'd2:    cur_val_s = dac_c_r;
            default: cur_val_s = 8'h00;
        endcase
    end

    assign win_onehot_s = NREQ'(1'b1) << win_idx_r;

    // Next-state and datapath decisions for the IDLE/LOAD/WAIT scheduler
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        win_idx_nxt_s   = win_idx_r;
        win_ch_nxt_s    = win_ch_r;
        win_data_nxt_s  = win_data_r;
        dac_a_nxt_s     = dac_a_r;
        dac_b_nxt_s     = dac_b_r;
        dac_c_nxt_s     = dac_c_r;
        ack_nxt_s       = {NREQ{1'b0}};
        nack_nxt_s      = {NREQ{1'b0}};
        err_nxt_s       = err_r;
        frame_cnt_nxt_s = frame_cnt_r;
        tmo_nxt_s       = tmo_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_found_s && pld_ready_r) begin
                    win_idx_nxt_s  = arb_idx_s;
                    win_ch_nxt_s   = arb_ch_s;
                    win_data_nxt_s = arb_data_s;
                    state_nxt_s    = ST_LOAD;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ptr_nxt_s = (win_idx_r == IW'(NREQ - 1)) ? {IW{1'b0}} : win_idx_r + IW'(1);
                if (win_ch_r == 2'd3) begin
                    nack_nxt_s  = win_onehot_s;
                    state_nxt_s = ST_IDLE;
                end else if (win_data_r == cur_val_s) begin
                    ack_nxt_s   = win_onehot_s;
                    state_nxt_s = ST_IDLE;
                end else begin
                    case (win_ch_r)
                        2'd0:    dac_a_nxt_s = win_data_r;
                        2'd1:    dac_b_nxt_s = win_data_r;
                        default: dac_c_nxt_s = win_data_r;
                    endcase
                    ack_nxt_s       = win_onehot_s;
                    frame_cnt_nxt_s = 4'(SYNC_FRAMES);
                    tmo_nxt_s       = 16'd0;
                    state_nxt_s     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_nxt_s = sync_edge_s ? 16'd0 : tmo_r + 16'd1;
                // Frames sent while the PLD is held in reset did not carry the value
                if (!pld_ready_r) begin
                    frame_cnt_nxt_s = 4'(SYNC_FRAMES);
                end else if (sync_edge_s) begin
                    frame_cnt_nxt_s = frame_cnt_r - 4'd1;
                end else begin
                    frame_cnt_nxt_s = frame_cnt_r;
                end
                if (pld_ready_r && sync_edge_s && (frame_cnt_r == 4'd1)) begin
                    frame_cnt_nxt_s = 4'd0;
                    tmo_nxt_s       = 16'd0;
                    state_nxt_s     = ST_IDLE;
                end else if (!sync_edge_s && (tmo_r == 16'(TIMEOUT - 1))) begin
                    err_nxt_s       = 1'b1;
                    frame_cnt_nxt_s = 4'd0;
                    tmo_nxt_s       = 16'd0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s     = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state, DAC holding registers and registered handshake outputs
    always_ff @(posedge CLK_24MHZ_FPGA) begin
        if (SYSRST) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IW{1'b0}};
            win_idx_r   <= {IW{1'b0}};
            win_ch_r    <= 2'd0;
            win_data_r  <= 8'h00;
            dac_a_r     <= 8'h80;
            dac_b_r     <= 8'h80;
            dac_c_r     <= 8'h80;
            ack_r       <= {NREQ{1'b0}};
            nack_r      <= {NREQ{1'b0}};
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            frame_cnt_r <= 4'd0;
            tmo_r       <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            win_idx_r   <= win_idx_nxt_s;
            win_ch_r    <= win_ch_nxt_s;
            win_data_r  <= win_data_nxt_s;
            dac_a_r     <= dac_a_nxt_s;
            dac_b_r     <= dac_b_nxt_s;
            dac_c_r     <= dac_c_nxt_s;
            ack_r       <= ack_nxt_s;
            nack_r      <= nack_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            err_r       <= err_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
            tmo_r       <= tmo_nxt_s;
        end
    end

    assign ACK      = ack_r;
    assign NACK     = nack_r;
    assign DAC_DINA = dac_a_r;
    assign DAC_DINB = dac_b_r;
    assign DAC_DINC = dac_c_r;
    assign BUSY     = busy_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler: two requesters, two-frame hold-off, short timeout.
module tb_dac_update_scheduler;
    localparam int NREQ        = 2;
    localparam int SYNC_FRAMES = 2;
    localparam int TIMEOUT     = 64;

    logic              CLK_24MHZ_FPGA = 1'b0;
    logic              SYSRST;
    logic [NREQ-1:0]   REQ;
    logic [2*NREQ-1:0] REQ_CH;
    logic [8*NREQ-1:0] REQ_DATA;
    logic [NREQ-1:0]   ACK;
    logic [NREQ-1:0]   NACK;
    logic              SYNC;
    logic              PLDRESETn;
    logic [7:0]        DAC_DINA, DAC_DINB, DAC_DINC;
    logic              BUSY;
    logic              ERR;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    dac_update_scheduler #(
        .NREQ(NREQ), .SYNC_FRAMES(SYNC_FRAMES), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_24MHZ_FPGA(CLK_24MHZ_FPGA), .SYSRST(SYSRST),
        .REQ(REQ), .REQ_CH(REQ_CH), .REQ_DATA(REQ_DATA),
        .ACK(ACK), .NACK(NACK),
        .SYNC(SYNC), .PLDRESETn(PLDRESETn),
        .DAC_DINA(DAC_DINA), .DAC_DINB(DAC_DINB), .DAC_DINC(DAC_DINC),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK_24MHZ_FPGA = ~CLK_24MHZ_FPGA;

    // Advance one clock and settle past the edge; inputs are driven and outputs sampled here
    task automatic tick();
        @(posedge CLK_24MHZ_FPGA);
        #1;
    endtask

    task automatic do_reset();
        SYSRST = 1'b1; REQ = 2'b00; REQ_CH = 4'h0; REQ_DATA = 16'h0000;
        SYNC = 1'b0; PLDRESETn = 1'b1;
        repeat (3) tick();
        SYSRST = 1'b0;
        repeat (3) tick();
    endtask

    // One stream frame marker; the synchronised rising edge is consumed on the final tick
    task automatic sync_pulse();
        SYNC = 1'b0;
        repeat (2) tick();
        SYNC = 1'b1;
        repeat (3) tick();
        SYNC = 1'b0;
    endtask

    task automatic test_reset();
        SYSRST = 1'b1; REQ = 2'b00; REQ_CH = 4'h0; REQ_DATA = 16'h0000;
        SYNC = 1'b0; PLDRESETn = 1'b1;
        repeat (3) tick();
        SYSRST = 1'b0;
        vec_cnt++;
        if ({DAC_DINA, DAC_DINB, DAC_DINC} !== 24'h808080) begin
            miss_cnt++; $display("FAIL reset_dac got %h want %h", {DAC_DINA, DAC_DINB, DAC_DINC}, 24'h808080);
        end
        vec_cnt++;
        if ({ACK, NACK, BUSY, ERR} !== 6'b000000) begin
            miss_cnt++; $display("FAIL reset_ctrl got %b want %b", {ACK, NACK, BUSY, ERR}, 6'b000000);
        end
        repeat (3) tick();
    endtask

    task automatic test_single_write();
        do_reset();
        REQ = 2'b01; REQ_CH = 4'b0000; REQ_DATA = 16'h0040;
        tick();
        vec_cnt++;
        if (ACK !== 2'b00) begin
            miss_cnt++; $display("FAIL single_early_ack got %b want %b", ACK, 2'b00);
        end
        tick();
        vec_cnt++;
        if (ACK !== 2'b01 || DAC_DINA !== 8'h40 || BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL single_ack got ack=%b a=%h busy=%b want ack=01 a=40 busy=1", ACK, DAC_DINA, BUSY);
        end
        REQ = 2'b00;
        tick();
        vec_cnt++;
        if (ACK !== 2'b00) begin
            miss_cnt++; $display("FAIL single_ack_pulse got %b want %b", ACK, 2'b00);
        end
        sync_pulse();
        vec_cnt++;
        if (BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL single_busy_after_1 got %b want %b", BUSY, 1'b1);
        end
        sync_pulse();
        vec_cnt++;
        if (BUSY !== 1'b0 || DAC_DINA !== 8'h40) begin
            miss_cnt++; $display("FAIL single_done got busy=%b a=%h want busy=0 a=40", BUSY, DAC_DINA);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        REQ = 2'b11; REQ_CH = {2'd2, 2'd1}; REQ_DATA = {8'h20, 8'h10};
        repeat (2) tick();
        vec_cnt++;
        if (ACK !== 2'b01 || DAC_DINB !== 8'h10) begin
            miss_cnt++; $display("FAIL b2b_first got ack=%b b=%h want ack=01 b=10", ACK, DAC_DINB);
        end
        REQ = 2'b10;
        sync_pulse();
        vec_cnt++;
        if (ACK !== 2'b00 || BUSY !== 1'b1 || DAC_DINC !== 8'h80) begin
            miss_cnt++; $display("FAIL b2b_held got ack=%b busy=%b c=%h want ack=00 busy=1 c=80", ACK, BUSY, DAC_DINC);
        end
        sync_pulse();
        vec_cnt++;
        if (ACK !== 2'b00 || BUSY !== 1'b0) begin
            miss_cnt++; $display("FAIL b2b_released got ack=%b busy=%b want ack=00 busy=0", ACK, BUSY);
        end
        repeat (2) tick();
        vec_cnt++;
        if (ACK !== 2'b10 || DAC_DINC !== 8'h20 || BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL b2b_second got ack=%b c=%h busy=%b want ack=10 c=20 busy=1", ACK, DAC_DINC, BUSY);
        end
        REQ = 2'b00;
    endtask

    task automatic test_nack();
        do_reset();
        REQ = 2'b10; REQ_CH = {2'd3, 2'd0}; REQ_DATA = {8'h5A, 8'h00};
        repeat (2) tick();
        vec_cnt++;
        if (NACK !== 2'b10 || ACK !== 2'b00) begin
            miss_cnt++; $display("FAIL nack_pulse got nack=%b ack=%b want nack=10 ack=00", NACK, ACK);
        end
        REQ = 2'b00;
        vec_cnt++;
        if ({DAC_DINA, DAC_DINB, DAC_DINC} !== 24'h808080 || BUSY !== 1'b0) begin
            miss_cnt++; $display("FAIL nack_nochange got dac=%h busy=%b want dac=808080 busy=0", {DAC_DINA, DAC_DINB, DAC_DINC}, BUSY);
        end
        tick();
        vec_cnt++;
        if (NACK !== 2'b00) begin
            miss_cnt++; $display("FAIL nack_one_cycle got %b want %b", NACK, 2'b00);
        end
    endtask

    task automatic test_same_value();
        do_reset();
        REQ = 2'b01; REQ_CH = 4'b0000; REQ_DATA = 16'h0080;
        repeat (2) tick();
        vec_cnt++;
        if (ACK !== 2'b01 || BUSY !== 1'b0) begin
            miss_cnt++; $display("FAIL same_ack got ack=%b busy=%b want ack=01 busy=0", ACK, BUSY);
        end
        REQ = 2'b00;
        tick();
        REQ = 2'b10; REQ_CH = {2'd1, 2'd0}; REQ_DATA = {8'h55, 8'h80};
        repeat (2) tick();
        vec_cnt++;
        if (ACK !== 2'b10 || DAC_DINB !== 8'h55) begin
            miss_cnt++; $display("FAIL same_follow got ack=%b b=%h want ack=10 b=55", ACK, DAC_DINB);
        end
        REQ = 2'b00;
    endtask

    task automatic test_pld_reset();
        do_reset();
        REQ = 2'b01; REQ_CH = 4'b0000; REQ_DATA = 16'h0033;
        repeat (2) tick();
        REQ = 2'b00;
        PLDRESETn = 1'b0;
        repeat (3) sync_pulse();
        vec_cnt++;
        if (BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL pld_hold got busy=%b want busy=1", BUSY);
        end
        PLDRESETn = 1'b1;
        sync_pulse();
        vec_cnt++;
        if (BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL pld_reload got busy=%b want busy=1", BUSY);
        end
        sync_pulse();
        vec_cnt++;
        if (BUSY !== 1'b0 || DAC_DINA !== 8'h33) begin
            miss_cnt++; $display("FAIL pld_done got busy=%b a=%h want busy=0 a=33", BUSY, DAC_DINA);
        end
        PLDRESETn = 1'b0;
        repeat (3) tick();
        REQ = 2'b01; REQ_DATA = 16'h0011;
        repeat (3) tick();
        vec_cnt++;
        if (ACK !== 2'b00 || BUSY !== 1'b0 || DAC_DINA !== 8'h33) begin
            miss_cnt++; $display("FAIL pld_no_grant got ack=%b busy=%b a=%h want ack=00 busy=0 a=33", ACK, BUSY, DAC_DINA);
        end
        PLDRESETn = 1'b1;
        repeat (4) tick();
        vec_cnt++;
        if (ACK !== 2'b01 || DAC_DINA !== 8'h11) begin
            miss_cnt++; $display("FAIL pld_grant got ack=%b a=%h want ack=01 a=11", ACK, DAC_DINA);
        end
        REQ = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        REQ = 2'b01; REQ_CH = 4'b0000; REQ_DATA = 16'h0077;
        repeat (2) tick();
        REQ = 2'b00;
        repeat (TIMEOUT - 1) tick();
        vec_cnt++;
        if (ERR !== 1'b0 || BUSY !== 1'b1) begin
            miss_cnt++; $display("FAIL tmo_early got err=%b busy=%b want err=0 busy=1", ERR, BUSY);
        end
        tick();
        vec_cnt++;
        if (ERR !== 1'b1 || BUSY !== 1'b0) begin
            miss_cnt++; $display("FAIL tmo_fire got err=%b busy=%b want err=1 busy=0", ERR, BUSY);
        end
        repeat (5) tick();
        vec_cnt++;
        if (ERR !== 1'b1) begin
            miss_cnt++; $display("FAIL tmo_sticky got err=%b want err=1", ERR);
        end
        do_reset();
        vec_cnt++;
        if (ERR !== 1'b0 || DAC_DINA !== 8'h80) begin
            miss_cnt++; $display("FAIL tmo_clear got err=%b a=%h want err=0 a=80", ERR, DAC_DINA);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_nack();
        test_same_value();
        test_pld_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
